// File: rtl/channel_scan_controller.sv
// channel_scan_controller
//   Steps an external 8-to-1 mux through channels 0..7. Each channel is held
//   for SETTLE_CYCLES settle cycles plus one sample cycle. The sampled bits
//   are assembled into an 8-bit word that is published at the end of a scan.
//   Scans run once (mode=0) or repeat back-to-back (mode=1) until stop.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   start         : scan request, only sampled in IDLE
//   mode          : 0 single scan, 1 continuous; latched when start is accepted
//   stop          : end after the current scan; sampled every busy cycle
//   mux_out       : output line of the downstream mux
//   selector_bits : channel select to the mux
//   busy          : scan in progress
//   word_valid    : one-cycle pulse when word updates
//   word          : last completed scan, bit k = channel k
//   scan_count    : completed scans, modulo 256
//
// State table
//   IDLE   | waiting for start, selector parked at 0
//   SETTLE | selector stable, letting the mux output settle
//   SAMPLE | capture mux_out into the shadow word on the exit edge
module channel_scan_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       stop,
  input  logic       mux_out,
  output logic [2:0] selector_bits,
  output logic       busy,
  output logic       word_valid,
  output logic [7:0] word,
  output logic [7:0] scan_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       word_valid_q, word_valid_d;
  logic [7:0] word_q, word_d;
  logic [7:0] scan_count_q, scan_count_d;
  logic       mode_q, mode_d;
  logic       stop_pending_q, stop_pending_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] shadow_q, shadow_d;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    busy_d         = busy_q;
    word_valid_d   = 1'b0;
    word_d         = word_q;
    scan_count_d   = scan_count_q;
    mode_d         = mode_q;
    stop_pending_d = stop_pending_q;
    settle_d       = settle_q;
    shadow_d       = shadow_q;

    if (busy_q && stop) begin
      stop_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = SETTLE;
          sel_d          = 3'd0;
          busy_d         = 1'b1;
          settle_d       = 4'd0;
          mode_d         = mode;
          // start together with stop yields exactly one scan
          stop_pending_d = stop;
          shadow_d       = 8'h00;
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      SAMPLE: begin
        shadow_d[sel_q] = mux_out;
        settle_d        = 4'd0;
        if (sel_q != 3'd7) begin
          sel_d   = sel_q + 3'd1;
          state_d = SETTLE;
        end else begin
          // word takes the shadow including the bit captured on this edge
          word_d       = shadow_d;
          word_valid_d = 1'b1;
          scan_count_d = scan_count_q + 8'd1;
          shadow_d     = 8'h00;
          sel_d        = 3'd0;
          // a stop arriving on this very edge also ends continuous mode
          if (mode_q && !(stop_pending_q || stop)) begin
            state_d = SETTLE;
          end else begin
            state_d        = IDLE;
            busy_d         = 1'b0;
            stop_pending_d = 1'b0;
          end
        end
      end

      default: begin
        state_d        = IDLE;
        busy_d         = 1'b0;
        sel_d          = 3'd0;
        stop_pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= 3'd0;
      busy_q         <= 1'b0;
      word_valid_q   <= 1'b0;
      word_q         <= 8'h00;
      scan_count_q   <= 8'h00;
      mode_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      settle_q       <= 4'd0;
      shadow_q       <= 8'h00;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      busy_q         <= busy_d;
      word_valid_q   <= word_valid_d;
      word_q         <= word_d;
      scan_count_q   <= scan_count_d;
      mode_q         <= mode_d;
      stop_pending_q <= stop_pending_d;
      settle_q       <= settle_d;
      shadow_q       <= shadow_d;
    end
  end

  assign selector_bits = sel_q;
  assign busy          = busy_q;
  assign word_valid    = word_valid_q;
  assign word          = word_q;
  assign scan_count    = scan_count_q;

endmodule

// File: tb/tb_channel_scan_controller.sv
// Bench for channel_scan_controller: two instances (SETTLE_CYCLES 1 and 3),
// each with a behavioural 8-to-1 mux on its selector. Expected words, counts
// and completion cycles are queued when a scan is launched and popped when
// word_valid pulses.
module tb_channel_scan_controller;

  logic       clk;
  logic       rst_n;

  logic       start1, mode1, stop1;
  logic [7:0] mux_in;
  logic       mux_out1;
  logic [2:0] sel1;
  logic       busy1, wv1;
  logic [7:0] word1, cnt1;

  logic       start3, mode3, stop3;
  logic [7:0] mux3_in;
  logic       mux_out3;
  logic [2:0] sel3;
  logic       busy3, wv3;
  logic [7:0] word3, cnt3;

  assign mux_out1 = mux_in[sel1];
  assign mux_out3 = mux3_in[sel3];

  channel_scan_controller #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .stop(stop1),
    .mux_out(mux_out1), .selector_bits(sel1), .busy(busy1),
    .word_valid(wv1), .word(word1), .scan_count(cnt1)
  );

  channel_scan_controller #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .stop(stop3),
    .mux_out(mux_out3), .selector_bits(sel3), .busy(busy3),
    .word_valid(wv3), .word(word3), .scan_count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int wv_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] cnt;
    int         cyc;
    bit         last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push_exp(input logic [7:0] w, input logic [7:0] c, input int t, input bit last);
    exp_t e;
    e.word = w; e.cnt = c; e.cyc = t; e.last = last;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (wv1) begin
      wv_cnt++;
      if (sb.size() == 0) begin
        chk("wv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("word", word1, mon_e.word);
        chk("scan_count", cnt1, mon_e.cnt);
        chk("wv_cycle", cyc, mon_e.cyc);
        if (mon_e.last) chk("busy_after_last", busy1, 32'd0);
      end
    end
  end

  task automatic wait_wv(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!wv1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!wv1) chk("wv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy1) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_cnt;
  int         t0;
  int         wv_before;
  int         n;

  initial begin
    rst_n = 1'b0;
    start1 = 0; mode1 = 0; stop1 = 0; mux_in = 8'h00;
    start3 = 0; mode3 = 0; stop3 = 0; mux3_in = 8'h00;
    exp_cnt = 8'h00;
    #3;
    chk("rst_sel", sel1, 32'd0);
    chk("rst_busy", busy1, 32'd0);
    chk("rst_wv", wv1, 32'd0);
    chk("rst_word", word1, 32'd0);
    chk("rst_count", cnt1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single scan A5, then restart on the cycle busy falls
    mux_in = 8'hA5; mode1 = 0; start1 = 1;
    exp_cnt = exp_cnt + 8'd1;
    push_exp(8'hA5, exp_cnt, cyc + 17, 1);
    @(negedge clk) start1 = 0;
    wait_wv(40);
    chk("busy_low_at_wv", busy1, 32'd0);
    mux_in = 8'h3C; start1 = 1;
    exp_cnt = exp_cnt + 8'd1;
    push_exp(8'h3C, exp_cnt, cyc + 17, 1);
    @(negedge clk) start1 = 0;
    chk("restart_busy", busy1, 32'd1);
    wait_idle(40);
    repeat (3) @(negedge clk);

    // SETTLE_CYCLES=3: each channel held 4 cycles, word after 32
    mux3_in = 8'h3C; start3 = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) start3 = 0;
      chk("sel3_hold", sel3, 32'(i / 4));
    end
    @(negedge clk);
    chk("word3", word3, 32'h3C);
    chk("wv3", wv3, 32'd1);
    chk("count3", cnt3, 32'd1);
    chk("busy3_end", busy3, 32'd0);
    @(negedge clk);
    chk("wv3_one_cycle", wv3, 32'd0);

    // start held through the scan, mode toggled while busy
    mux_in = 8'h96; mode1 = 0; start1 = 1;
    exp_cnt = exp_cnt + 8'd1;
    push_exp(8'h96, exp_cnt, cyc + 17, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 5) mode1 = 1;
    end
    start1 = 0; mode1 = 0;
    wait_idle(40);
    repeat (20) @(negedge clk);
    chk("held_no_restart", busy1, 32'd0);

    // start and stop together in IDLE with mode=1 -> one scan
    mux_in = 8'h5A; mode1 = 1; start1 = 1; stop1 = 1;
    exp_cnt = exp_cnt + 8'd1;
    push_exp(8'h5A, exp_cnt, cyc + 17, 1);
    @(negedge clk);
    start1 = 0; stop1 = 0; mode1 = 0;
    wait_idle(40);
    repeat (20) @(negedge clk);
    chk("start_stop_one_scan", busy1, 32'd0);

    // continuous, FF then 00, stop during scan 3
    mux_in = 8'hFF; mode1 = 1; start1 = 1;
    t0 = cyc;
    push_exp(8'hFF, exp_cnt + 8'd1, t0 + 17, 0);
    push_exp(8'h00, exp_cnt + 8'd2, t0 + 33, 0);
    push_exp(8'h00, exp_cnt + 8'd3, t0 + 49, 1);
    exp_cnt = exp_cnt + 8'd3;
    @(negedge clk) start1 = 0;
    wait_wv(40);
    mux_in = 8'h00;
    wait_wv(40);
    chk("cont_busy", busy1, 32'd1);
    stop1 = 1;
    @(negedge clk) stop1 = 0;
    wait_idle(40);
    mode1 = 0;
    repeat (5) @(negedge clk);

    // reset at selector 5: immediate clear, no word_valid, clean restart
    mux_in = 8'hA5; mode1 = 0; start1 = 1;
    @(negedge clk) start1 = 0;
    n = 0;
    while (sel1 != 3'd5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sel5", sel1, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", sel1, 32'd0);
    chk("async_rst_busy", busy1, 32'd0);
    chk("async_rst_wv", wv1, 32'd0);
    chk("async_rst_word", word1, 32'd0);
    chk("async_rst_count", cnt1, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = 8'h00;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", busy1, 32'd0);
    chk("post_rst_word", word1, 32'd0);
    start1 = 1;
    exp_cnt = exp_cnt + 8'd1;
    push_exp(8'hA5, exp_cnt, cyc + 17, 1);
    @(negedge clk) start1 = 0;
    wait_idle(40);
    repeat (3) @(negedge clk);

    // 256 continuous scans, count wraps through 00
    mux_in = 8'hC3; mode1 = 1; start1 = 1;
    t0 = cyc;
    wv_before = wv_cnt;
    for (int k = 0; k < 256; k++) begin
      push_exp(8'hC3, exp_cnt + 8'(k + 1), t0 + 17 + 16 * k, k == 255);
    end
    @(negedge clk) start1 = 0;
    repeat (255) wait_wv(40);
    stop1 = 1;
    @(negedge clk) stop1 = 0;
    wait_idle(40);
    @(negedge clk);
    mode1 = 0;
    chk("wv_count_256", wv_cnt - wv_before, 32'd256);
    chk("count_after_256", cnt1, exp_cnt);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/channel_scan_controller.md
CHANNEL_SCAN_CONTROLLER -- requirements
Module: channel_scan_controller

Interface
REQ-001 Parameter: SETTLE_CYCLES, 1, cycles selector_bits is held before each sample; legal range 1..15.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as follows.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  request a scan; sampled only in IDLE.
REQ-006 mode  input  1  0 = single scan, 1 = continuous; latched on accepted start.
REQ-007 stop  input  1  request termination after the current scan; sampled every cycle while busy.
REQ-008 mux_out  input  1  output_line of the downstream 8-to-1 mux.
REQ-009 selector_bits  output  3  channel select driven to the 8-to-1 mux.
REQ-010 busy  output  1  high while a scan is in progress.
REQ-011 word_valid  output  1  one-cycle pulse when word updates.
REQ-012 word  output  8  last completed scan; bit k = mux_out sampled with selector_bits == k.
REQ-013 scan_count  output  8  completed scans, modulo 256.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE and SAMPLE; all outputs are registered.
REQ-015 IDLE + start=1 at edge E0 -> SETTLE, selector_bits=0, busy=1, settle counter=0, mode latched.
REQ-016 SETTLE: the counter increments each cycle; on the edge where it reaches SETTLE_CYCLES-1, the FSM goes to SAMPLE.
REQ-017 SAMPLE: mux_out is captured into shadow bit [selector_bits] on the next edge.
REQ-018 If selector_bits<7 on that edge: selector_bits+1, FSM returns to SETTLE, counter cleared.
REQ-019 selector_bits SHALL change only on SAMPLE exit; it is constant throughout SETTLE and SAMPLE of a channel.
REQ-020 Each channel SHALL take SETTLE_CYCLES+1 cycles; one scan is 8*(SETTLE_CYCLES+1) cycles.
REQ-021 When selector_bits=7 and SAMPLE exits, on the same edge:
- word <= shadow with bit 7 = mux_out;
- word_valid=1 for exactly one cycle;
- scan_count+1, wrapping 255->0.
REQ-022 Latency: word_valid is high in the cycle starting 8*(SETTLE_CYCLES+1) edges after E0 (16 for SETTLE_CYCLES=1).
REQ-023 Final SAMPLE exit routing:
- latched mode=1 and no stop pending -> SETTLE with selector_bits=0; busy stays 1; no idle gap.
- otherwise -> IDLE, busy=0, selector_bits=0.
REQ-024 stop while busy SHALL set stop_pending; the current scan completes, and stop_pending clears on entry to IDLE.
REQ-025 start while busy SHALL be ignored; mode changes while busy SHALL be ignored.
REQ-026 start and stop both high in IDLE SHALL start a scan with stop_pending set, i.e. exactly one scan.
REQ-027 word SHALL hold its value between completions; partial scans never update word.
REQ-028 A restart from IDLE SHALL be accepted on the edge after busy falls.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, selector_bits=0, busy=0, word_valid=0, word=8'h00, scan_count=8'h00, stop_pending=0, counter=0, shadow=0.
REQ-030 Reset mid-scan SHALL discard the partial word and produce no word_valid; operation resumes only on a new start after rst_n=1.

Verification
REQ-031 Bench models the 8-to-1 mux with inputs 8'hA5; SETTLE_CYCLES=1, single scan -> word=8'hA5, word_valid pulse 16 cycles after start, scan_count=1, busy low the next cycle.
REQ-032 SETTLE_CYCLES=3, inputs 8'h3C -> each selector value is held 4 cycles; word=8'h3C after 32 cycles.
REQ-033 mode=1, inputs 8'hFF then 8'h00 changed mid-run, stop asserted during scan 3 -> three word_valid pulses 16 cycles apart, no gap between scans, then IDLE; scan_count=3.
REQ-034 Continuous mode for 256 scans -> scan_count wraps to 8'h00; word_valid count = 256.
REQ-035 rst_n pulsed low at selector_bits=5 -> all outputs at reset values asynchronously; no word_valid; a new start gives a full 16-cycle scan.
REQ-036 start held high during busy, plus start and stop together in IDLE -> only one scan each; no restart until busy falls.
